meas_frame_tx: RTL and testbench

MEAS_FRAME_TX -- requirements
Module: meas_frame_tx

---
 rtl/meas_frame_tx.sv | 202 ++++++++++++++++++++
 tb/tb_meas_frame_tx.sv | 381 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/meas_frame_tx.sv
// Periodic ASCII measurement frame transmitter: per-channel live/min/max/freeze
// registers, a frame timer and a byte-serialising FSM feeding a UART FIFO.
module meas_frame_tx #(
    parameter int N_CH   = 13,
    parameter int PERIOD = 65000000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [1:0]        mode,
    input  logic              clr_hold,
    input  logic              sample_stb,
    input  logic [16*N_CH-1:0] din,
    input  logic              tx_full,
    output logic [7:0]        tx_data,
    output logic              tx_wr,
    output logic              busy,
    output logic              overrun,
    output logic [2:0]        dbg_state
);

    typedef enum logic [2:0] {IDLE, LATCH, CHAR, WAIT, EOL} state_t;

    localparam int              TW        = $clog2(PERIOD);
    localparam logic [TW-1:0]   T_LAST    = TW'(PERIOD - 1);
    localparam logic [3:0]      LAST_TENS = 4'((N_CH - 1) / 10);
    localparam logic [3:0]      LAST_ONES = 4'((N_CH - 1) % 10);

    logic [TW-1:0]             timer;
    logic                      trigger;
    logic                      pending;
    logic [N_CH-1:0][15:0]     live, mn, mx, frz;
    logic                      frz_armed;
    logic [16*N_CH-1:0]        sel, snap;
    state_t                    state;
    logic [3:0]                pos, tens, ones;
    logic                      last_ch, eol_phase;
    logic [1:0]                eol_cnt;
    logic [7:0]                chan_byte;

    function automatic logic [7:0] digit(input logic [3:0] n);
        return (n > 4'd9) ? 8'h3F : (8'h30 + {4'h0, n});
    endfunction

    assign trigger   = en && (timer == T_LAST);
    assign dbg_state = state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            timer <= '0;
        end else if (!en || timer == T_LAST) begin
            timer <= '0;
        end else begin
            timer <= timer + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            live      <= '0;
            frz       <= '0;
            frz_armed <= 1'b1;
            for (int k = 0; k < N_CH; k++) begin
                mn[k] <= 16'h9999;
                mx[k] <= 16'h0000;
            end
        end else begin
            for (int k = 0; k < N_CH; k++) begin
                if (sample_stb) live[k] <= din[16*k +: 16];
                if (clr_hold && sample_stb) begin
                    mn[k]  <= din[16*k +: 16];
                    mx[k]  <= din[16*k +: 16];
                    frz[k] <= din[16*k +: 16];
                end else if (clr_hold) begin
                    mn[k] <= 16'h9999;
                    mx[k] <= 16'h0000;
                end else if (sample_stb) begin
                    if (din[16*k +: 16] < mn[k]) mn[k] <= din[16*k +: 16];
                    if (din[16*k +: 16] > mx[k]) mx[k] <= din[16*k +: 16];
                    if (frz_armed) frz[k] <= din[16*k +: 16];
                end
            end
            // Freeze captures only the first sample after a clear.
            if (clr_hold)        frz_armed <= !sample_stb;
            else if (sample_stb) frz_armed <= 1'b0;
        end
    end

    always_comb begin
        sel = '0;
        for (int k = 0; k < N_CH; k++) begin
            case (mode)
                2'd0:    sel[16*k +: 16] = live[k];
                2'd1:    sel[16*k +: 16] = mn[k];
                2'd2:    sel[16*k +: 16] = mx[k];
                default: sel[16*k +: 16] = frz[k];
            endcase
        end
    end

    // The snapshot shifts down one channel per field, so the current value is always the low word.
    always_comb begin
        chan_byte = 8'h20;
        case (pos)
            4'd0:    chan_byte = digit(tens);
            4'd1:    chan_byte = digit(ones);
            4'd2:    chan_byte = 8'h3A;
            4'd3:    chan_byte = digit(snap[15:12]);
            4'd4:    chan_byte = 8'h2E;
            4'd5:    chan_byte = digit(snap[11:8]);
            4'd6:    chan_byte = digit(snap[7:4]);
            4'd7:    chan_byte = digit(snap[3:0]);
            default: chan_byte = 8'h20;
        endcase
    end

    assign last_ch = (tens == LAST_TENS) && (ones == LAST_ONES);

    // Handshake: a byte is issued on an edge where the FSM is in CHAR/EOL and tx_full=0;
    // tx_wr is high for exactly the following cycle, tx_data holds otherwise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            pending   <= 1'b0;
            overrun   <= 1'b0;
            busy      <= 1'b0;
            tx_wr     <= 1'b0;
            tx_data   <= 8'h00;
            snap      <= '0;
            pos       <= '0;
            tens      <= '0;
            ones      <= '0;
            eol_phase <= 1'b0;
            eol_cnt   <= '0;
        end else begin
            tx_wr <= 1'b0;
            if (trigger) begin
                if (pending || state != IDLE) overrun <= 1'b1;
                else                          pending <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (pending) begin
                        pending <= 1'b0;
                        busy    <= 1'b1;
                        state   <= LATCH;
                    end
                end
                LATCH: begin
                    snap      <= sel;
                    pos       <= '0;
                    tens      <= '0;
                    ones      <= '0;
                    eol_phase <= 1'b0;
                    eol_cnt   <= '0;
                    state     <= CHAR;
                end
                CHAR: begin
                    if (!tx_full) begin
                        tx_wr   <= 1'b1;
                        tx_data <= chan_byte;
                        state   <= WAIT;
                        if (pos == 4'd8) begin
                            pos  <= '0;
                            snap <= snap >> 16;
                            if (last_ch) begin
                                eol_phase <= 1'b1;
                            end else if (ones == 4'd9) begin
                                ones <= '0;
                                tens <= tens + 1'b1;
                            end else begin
                                ones <= ones + 1'b1;
                            end
                        end else begin
                            pos <= pos + 1'b1;
                        end
                    end
                end
                WAIT: begin
                    if (eol_cnt == 2'd2) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else if (eol_phase) begin
                        state <= EOL;
                    end else begin
                        state <= CHAR;
                    end
                end
                EOL: begin
                    if (!tx_full) begin
                        tx_wr   <= 1'b1;
                        tx_data <= (eol_cnt == 2'd0) ? 8'h0D : 8'h0A;
                        eol_cnt <= eol_cnt + 1'b1;
                        state   <= WAIT;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_meas_frame_tx.sv
// Bench for meas_frame_tx: two instances (PERIOD=100 and PERIOD=20, N_CH=2) with
// byte scoreboards fed from expected frame text.
module tb_meas_frame_tx;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0, en_b = 1'b0;
    logic [1:0]  mode = 2'd0;
    logic        clr_hold = 1'b0;
    logic        sample_stb = 1'b0;
    logic [31:0] din = '0;
    logic        tx_full = 1'b0, tx_full_b = 1'b0;
    logic [7:0]  tx_data, tx_data_b;
    logic        tx_wr, tx_wr_b, busy, busy_b, overrun, overrun_b;
    logic [2:0]  dbg_state, dbg_state_b;

    meas_frame_tx #(.N_CH(2), .PERIOD(100)) dut (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .clr_hold(clr_hold),
        .sample_stb(sample_stb), .din(din), .tx_full(tx_full),
        .tx_data(tx_data), .tx_wr(tx_wr), .busy(busy), .overrun(overrun),
        .dbg_state(dbg_state)
    );

    meas_frame_tx #(.N_CH(2), .PERIOD(20)) dut_b (
        .clk(clk), .rst(rst), .en(en_b), .mode(mode), .clr_hold(clr_hold),
        .sample_stb(sample_stb), .din(din), .tx_full(tx_full_b),
        .tx_data(tx_data_b), .tx_wr(tx_wr_b), .busy(busy_b), .overrun(overrun_b),
        .dbg_state(dbg_state_b)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] exp_q[$];
    logic [7:0] exp_q_b[$];
    int         wr_cyc[$];
    int         wr_cnt_b = 0;
    int         done_cyc = 0;
    logic [7:0] mon_e, mon_e_b;

    always @(negedge clk) begin
        if (tx_wr === 1'b1) begin
            wr_cyc.push_back(cyc);
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_wr got %02h expected no write", tx_data);
            end else begin
                mon_e = exp_q.pop_front();
                if (tx_data !== mon_e) begin
                    errors++;
                    $display("FAIL byte got %02h expected %02h at cycle %0d", tx_data, mon_e, cyc);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (tx_wr_b === 1'b1) begin
            wr_cnt_b++;
            checks++;
            if (exp_q_b.size() == 0) begin
                errors++;
                $display("FAIL unexpected_wr_b got %02h expected no write", tx_data_b);
            end else begin
                mon_e_b = exp_q_b.pop_front();
                if (tx_data_b !== mon_e_b) begin
                    errors++;
                    $display("FAIL byte_b got %02h expected %02h", tx_data_b, mon_e_b);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got timeout expected completion");
        $fatal(1, "watchdog");
    end

    function automatic logic [7:0] asc(input logic [3:0] n);
        return (n > 4'd9) ? 8'h3F : 8'(48 + int'(n));
    endfunction

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push_frame(input logic [15:0] c0, input logic [15:0] c1, input bit to_b);
        logic [7:0]  f[$];
        logic [15:0] v;
        for (int k = 0; k < 2; k++) begin
            v = (k == 0) ? c0 : c1;
            f.push_back(8'h30);
            f.push_back(8'(48 + k));
            f.push_back(8'h3A);
            f.push_back(asc(v[15:12]));
            f.push_back(8'h2E);
            f.push_back(asc(v[11:8]));
            f.push_back(asc(v[7:4]));
            f.push_back(asc(v[3:0]));
            f.push_back(8'h20);
        end
        f.push_back(8'h0D);
        f.push_back(8'h0A);
        foreach (f[i]) begin
            if (to_b) exp_q_b.push_back(f[i]);
            else      exp_q.push_back(f[i]);
        end
    endtask

    task automatic sample(input logic [15:0] c0, input logic [15:0] c1, input logic clr);
        din = {c1, c0};
        sample_stb = 1'b1;
        clr_hold = clr;
        tick(1);
        sample_stb = 1'b0;
        clr_hold = 1'b0;
    endtask

    task automatic wait_done(input string name);
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            #1;
            if (exp_q.size() == 0 && busy === 1'b0) break;
        end
        done_cyc = cyc;
        checks++;
        if (exp_q.size() != 0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL %s_done got left=%0d busy=%b expected left=0 busy=0", name, exp_q.size(), busy);
        end
    endtask

    task automatic wait_writes(input string name, input int n);
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            #1;
            if (wr_cyc.size() >= n) break;
        end
        checks++;
        if (wr_cyc.size() < n) begin
            errors++;
            $display("FAIL %s_reach got %0d writes expected %0d", name, wr_cyc.size(), n);
        end
    endtask

    task automatic run_frame(input string name, input logic [15:0] c0, input logic [15:0] c1);
        int t0;
        wr_cyc.delete();
        push_frame(c0, c1, 1'b0);
        t0 = cyc;
        en = 1'b1;
        wait_done(name);
        en = 1'b0;
        checks++;
        if (wr_cyc.size() != 20) begin
            errors++;
            $display("FAIL %s_len got %0d expected 20", name, wr_cyc.size());
        end
        checks++;
        if (wr_cyc.size() == 0 || wr_cyc[0] != t0 + 103) begin
            errors++;
            $display("FAIL %s_first got %0d expected %0d", name,
                     (wr_cyc.size() > 0) ? wr_cyc[0] - t0 : -1, 103);
        end
        tick(2);
    endtask

    task automatic test_reset();
        tick(3);
        checks++;
        if (tx_wr !== 1'b0 || tx_data !== 8'h00 || busy !== 1'b0 || overrun !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs got wr=%b data=%02h busy=%b ovr=%b expected 0 00 0 0",
                     tx_wr, tx_data, busy, overrun);
        end
        checks++;
        if (dbg_state !== 3'd0 || dbg_state_b !== 3'd0 || busy_b !== 1'b0 || overrun_b !== 1'b0) begin
            errors++;
            $display("FAIL reset_state got st=%0d st_b=%0d busy_b=%b ovr_b=%b expected 0 0 0 0",
                     dbg_state, dbg_state_b, busy_b, overrun_b);
        end
        rst = 1'b0;
        tick(2);
    endtask

    task automatic test_basic();
        int bad;
        mode = 2'd0;
        sample(16'h1234, 16'h2500, 1'b0);
        run_frame("basic", 16'h1234, 16'h2500);
        bad = 0;
        for (int i = 1; i < wr_cyc.size(); i++) if (wr_cyc[i] - wr_cyc[i-1] != 2) bad++;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL basic_spacing got %0d bad gaps expected 0", bad);
        end
        checks++;
        if (wr_cyc.size() == 0 || done_cyc != wr_cyc[wr_cyc.size()-1] + 1) begin
            errors++;
            $display("FAIL basic_busy_fall got cycle %0d expected last write + 1", done_cyc);
        end
        checks++;
        if (overrun !== 1'b0) begin
            errors++;
            $display("FAIL basic_overrun got %b expected 0", overrun);
        end
    endtask

    task automatic test_backpressure();
        int f_cyc;
        wr_cyc.delete();
        push_frame(16'h1234, 16'h2500, 1'b0);
        en = 1'b1;
        wait_writes("bp", 3);
        tx_full = 1'b1;
        tick(10);
        #1;
        checks++;
        if (wr_cyc.size() != 3) begin
            errors++;
            $display("FAIL bp_hold got %0d writes expected 3", wr_cyc.size());
        end
        tx_full = 1'b0;
        f_cyc = cyc;
        wait_done("bp");
        en = 1'b0;
        checks++;
        if (wr_cyc.size() != 20) begin
            errors++;
            $display("FAIL bp_len got %0d expected 20", wr_cyc.size());
        end
        checks++;
        if (wr_cyc.size() < 4 || wr_cyc[3] != f_cyc + 1) begin
            errors++;
            $display("FAIL bp_resume got %0d expected %0d", (wr_cyc.size() > 3) ? wr_cyc[3] : -1, f_cyc + 1);
        end
        tick(2);
    endtask

    task automatic test_snapshot();
        wr_cyc.delete();
        push_frame(16'h1234, 16'h2500, 1'b0);
        en = 1'b1;
        wait_writes("snap", 1);
        mode = 2'd2;
        sample(16'h9999, 16'h8888, 1'b0);
        wait_done("snap");
        en = 1'b0;
        mode = 2'd0;
        checks++;
        if (wr_cyc.size() != 20) begin
            errors++;
            $display("FAIL snap_len got %0d expected 20", wr_cyc.size());
        end
        tick(2);
    endtask

    task automatic test_bcd();
        mode = 2'd0;
        sample(16'h0042, 16'h1A00, 1'b0);
        run_frame("bcd", 16'h0042, 16'h1A00);
    endtask

    task automatic test_hold();
        clr_hold = 1'b1;
        tick(1);
        clr_hold = 1'b0;
        sample(16'h1234, 16'h0500, 1'b0);
        sample(16'h0999, 16'h0700, 1'b0);
        sample(16'h3000, 16'h0100, 1'b0);
        mode = 2'd1; run_frame("min", 16'h0999, 16'h0100);
        mode = 2'd2; run_frame("max", 16'h3000, 16'h0700);
        mode = 2'd3; run_frame("frz", 16'h1234, 16'h0500);
        sample(16'h0500, 16'h0800, 1'b1);
        mode = 2'd1; run_frame("clr_min", 16'h0500, 16'h0800);
        mode = 2'd2; run_frame("clr_max", 16'h0500, 16'h0800);
        mode = 2'd3; run_frame("clr_frz", 16'h0500, 16'h0800);
        mode = 2'd0;
    endtask

    task automatic test_overrun();
        mode = 2'd0;
        sample(16'h0300, 16'h0200, 1'b0);
        push_frame(16'h0300, 16'h0200, 1'b1);
        tx_full_b = 1'b1;
        en_b = 1'b1;
        tick(21);
        checks++;
        if (busy_b !== 1'b1 || overrun_b !== 1'b0) begin
            errors++;
            $display("FAIL ovr_first got busy=%b ovr=%b expected 1 0", busy_b, overrun_b);
        end
        tick(20);
        checks++;
        if (overrun_b !== 1'b1) begin
            errors++;
            $display("FAIL ovr_second got %b expected 1", overrun_b);
        end
        checks++;
        if (wr_cnt_b != 0) begin
            errors++;
            $display("FAIL ovr_nowrite got %0d writes expected 0", wr_cnt_b);
        end
        en_b = 1'b0;
        tx_full_b = 1'b0;
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            #1;
            if (exp_q_b.size() == 0 && busy_b === 1'b0) break;
        end
        checks++;
        if (wr_cnt_b != 20 || overrun_b !== 1'b1) begin
            errors++;
            $display("FAIL ovr_frame got writes=%0d ovr=%b expected 20 1", wr_cnt_b, overrun_b);
        end
        tick(50);
        checks++;
        if (wr_cnt_b != 20 || busy_b !== 1'b0) begin
            errors++;
            $display("FAIL ovr_single got writes=%0d busy=%b expected 20 0", wr_cnt_b, busy_b);
        end
    endtask

    task automatic test_reset_midframe();
        int t0;
        mode = 2'd0;
        wr_cyc.delete();
        push_frame(16'h0300, 16'h0200, 1'b0);
        en = 1'b1;
        wait_writes("rstmid", 5);
        rst = 1'b1;
        #1;
        checks++;
        if (tx_wr !== 1'b0 || busy !== 1'b0 || dbg_state !== 3'd0) begin
            errors++;
            $display("FAIL rstmid_now got wr=%b busy=%b st=%0d expected 0 0 0", tx_wr, busy, dbg_state);
        end
        exp_q.delete();
        mode = 2'd1;
        tick(3);
        wr_cyc.delete();
        rst = 1'b0;
        t0 = cyc;
        push_frame(16'h9999, 16'h9999, 1'b0);
        wait_done("rstmid");
        en = 1'b0;
        checks++;
        if (wr_cyc.size() != 20) begin
            errors++;
            $display("FAIL rstmid_len got %0d expected 20", wr_cyc.size());
        end
        checks++;
        if (wr_cyc.size() == 0 || wr_cyc[0] != t0 + 103) begin
            errors++;
            $display("FAIL rstmid_first got %0d expected %0d",
                     (wr_cyc.size() > 0) ? wr_cyc[0] - t0 : -1, 103);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_snapshot();
        test_bcd();
        test_hold();
        test_overrun();
        test_reset_midframe();
        tick(4);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
